// File: rtl/spw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spw_pkg
// Description : Shared SpaceWire receive constants: control characters, credit
//               FSM state encoding and the FCT credit quantum.
// Revision    : 1.0 - initial release
// ============================================================================
package spw_pkg;

    typedef logic [8:0] spw_char_t;

    localparam spw_char_t c_EOP = 9'h100;
    localparam spw_char_t c_EEP = 9'h101;

    localparam int c_FCT_QUANTUM = 8;

    typedef enum logic [0:0] {
        CR_IDLE = 1'b0,
        CR_REQ  = 1'b1
    } cr_state_t;

endpackage
`default_nettype wire

// File: rtl/rx_credit_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_credit_fifo_if
// Description : Link-side, consumer-side and credit handshake signals of the
//               receive credit FIFO. The slave modport is the FIFO itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_credit_fifo_if
    import spw_pkg::*;
#(
    parameter int DEPTH = 64
) ();
    logic                     link_run;
    logic                     rx_buffer_write;
    spw_char_t                rx_data_flag;
    logic                     rd_en;
    spw_char_t                rd_data;
    logic                     rd_empty;
    logic                     fct_send_req;
    logic                     fct_send_ack;
    logic                     credit_error;
    logic                     overflow;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport master (
        output link_run, rx_buffer_write, rx_data_flag, rd_en, fct_send_ack,
        input  rd_data, rd_empty, fct_send_req, credit_error, overflow, fifo_count
    );

    modport slave (
        input  link_run, rx_buffer_write, rx_data_flag, rd_en, fct_send_ack,
        output rd_data, rd_empty, fct_send_req, credit_error, overflow, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/spw_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : spw_fifo_mem
// Description : Dual-port character storage, synchronous write and
//               asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module spw_fifo_mem #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 9
) (
    input  wire logic                     clk,
    input  wire logic                     i_wr_en,
    input  wire logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  wire logic [WIDTH-1:0]         i_wr_data,
    input  wire logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic      [WIDTH-1:0]         o_rd_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule
`default_nettype wire

// File: rtl/rx_credit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rx_credit_fifo
// Description : SpaceWire receive FIFO with FCT credit accounting. Optional
//               EEP insertion on link loss is enabled by RX_CREDIT_EEP_INSERT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_credit_fifo
    import spw_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int MAX_CREDIT = 56
) (
    input wire logic          pclk,
    input wire logic          reset,
    rx_credit_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]  r_outstanding, w_out_nxt;
    cr_state_t      r_state, w_state_nxt;
    logic           r_credit_error, r_overflow;
    logic           w_full, w_empty, w_pop;
    logic           w_wr_req, w_wr_en, w_rx_acc, w_eep_wr;
    spw_char_t      w_wr_data;
    logic           w_ack, w_cr_ok, w_fct_req;
    logic [CW-1:0]  w_count;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A write to an empty FIFO cannot be popped in the same cycle: w_empty
    // reflects the registered pointers only.
    assign w_pop     = bus.rd_en & ~w_empty;
    assign w_wr_req  = bus.rx_buffer_write | w_eep_wr;
    assign w_wr_en   = w_wr_req & (~w_full | w_pop);
    assign w_rx_acc  = bus.rx_buffer_write & w_wr_en;
    assign w_wr_data = w_eep_wr ? c_EEP : bus.rx_data_flag;

`ifdef RX_CREDIT_EEP_INSERT_EN
    logic r_link_q, r_pkt_open, r_eep_pend, w_eep_req;

    // Insertion yields to a link write in the same cycle and retries after.
    assign w_eep_req = (r_link_q & ~bus.link_run & r_pkt_open) | r_eep_pend;
    assign w_eep_wr  = w_eep_req & ~bus.rx_buffer_write;

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_link_q   <= 1'b0;
            r_pkt_open <= 1'b0;
            r_eep_pend <= 1'b0;
        end else begin
            r_link_q   <= bus.link_run;
            r_eep_pend <= w_eep_req & bus.rx_buffer_write;
            if (w_eep_wr) begin
                r_pkt_open <= 1'b0;
            end else if (w_rx_acc) begin
                r_pkt_open <= ~bus.rx_data_flag[8];
            end
        end
    end
`else
    assign w_eep_wr = 1'b0;
`endif

    spw_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_mem (
        .clk       (pclk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (w_wr_data),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (bus.rd_data)
    );

    // Room for one more quantum must exist beyond what is already buffered
    // and what the far end is still entitled to send.
    assign w_cr_ok = ((CW+2)'(w_count) + (CW+2)'(r_outstanding) +
                      (CW+2)'(c_FCT_QUANTUM) <= (CW+2)'(DEPTH)) &&
                     (r_outstanding <= CW'(MAX_CREDIT - c_FCT_QUANTUM));
    assign w_ack   = (r_state == CR_REQ) & bus.fct_send_ack;

    always_comb begin
        w_state_nxt = r_state;
        w_fct_req   = 1'b0;
        unique case (r_state)
            CR_IDLE: if (bus.link_run && w_cr_ok) w_state_nxt = CR_REQ;
            CR_REQ: begin
                w_fct_req = 1'b1;
                if (bus.fct_send_ack) w_state_nxt = CR_IDLE;
            end
            default: w_state_nxt = CR_IDLE;
        endcase
        if (!bus.link_run) w_state_nxt = CR_IDLE;

        w_out_nxt = r_outstanding;
        if (w_rx_acc && r_outstanding != '0) w_out_nxt = w_out_nxt - CW'(1);
        if (w_ack) w_out_nxt = w_out_nxt + CW'(c_FCT_QUANTUM);
        if (!bus.link_run) w_out_nxt = '0;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_outstanding  <= '0;
            r_state        <= CR_IDLE;
            r_credit_error <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            r_outstanding <= w_out_nxt;
            r_state       <= w_state_nxt;
            if (bus.rx_buffer_write && r_outstanding == '0) r_credit_error <= 1'b1;
            if (w_wr_req && !w_wr_en) r_overflow <= 1'b1;
        end
    end

    assign bus.rd_empty     = w_empty;
    assign bus.fifo_count   = w_count;
    assign bus.fct_send_req = w_fct_req;
    assign bus.credit_error = r_credit_error;
    assign bus.overflow     = r_overflow;
endmodule
`default_nettype wire
